// File: rtl/opr1_sequencer_if.sv
// Request/strobe bundle between decode logic, the group-1 operate sequencer
// and the AC/rotater/Link datapath.
interface opr1_sequencer_if;
  // Handshake: the master raises start with ir valid while busy is low. The
  // sequencer accepts on that edge, raises busy the next cycle, and pulses done
  // for one cycle at the end. ir must stay stable until done. start while busy
  // is dropped, not queued.
  logic        start;
  logic [11:0] ir;
  logic        iac_carry;
  logic        busy;
  logic        done;
  logic        ac_ck;
  logic        ac_clr;
  logic        ac_cmp;
  logic        ac_inc;
  logic        rot_left;
  logic        rot_right;
  logic        rot_bsw;
  logic        link_ck;
  logic        link_cll;
  logic        link_cml;
  logic        link_set;

  modport master (
    output start, ir, iac_carry,
    input  busy, done, ac_ck, ac_clr, ac_cmp, ac_inc,
           rot_left, rot_right, rot_bsw, link_ck, link_cll, link_cml, link_set
  );

  modport slave (
    input  start, ir, iac_carry,
    output busy, done, ac_ck, ac_clr, ac_cmp, ac_inc,
           rot_left, rot_right, rot_bsw, link_ck, link_cll, link_cml, link_set
  );
endinterface

// File: rtl/opr1_sequencer.sv
// PDP-8 group-1 operate sequencer: steps clear, complement, increment and
// rotate, issuing one-cycle clock enables to the AC, rotater and Link.
module opr1_sequencer (
  input  logic              clk,
  input  logic              reset,
  opr1_sequencer_if.slave   bus,
  output logic [6:0]        state_o
);

  localparam logic [6:0] ST_IDLE = 7'b0000001;
  localparam logic [6:0] ST_CLR  = 7'b0000010;
  localparam logic [6:0] ST_CMP  = 7'b0000100;
  localparam logic [6:0] ST_INC  = 7'b0001000;
  localparam logic [6:0] ST_ROT1 = 7'b0010000;
  localparam logic [6:0] ST_ROT2 = 7'b0100000;
  localparam logic [6:0] ST_DONE = 7'b1000000;

  logic [6:0] state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic [4:0] en_q;

  // Step enables {ROT2, ROT1, INC, CMP, CLR} from the low 8 instruction bits.
  function automatic logic [4:0] step_en(input logic [7:0] v);
    logic rar, ral, two;
    rar = v[3];
    ral = v[2];
    two = v[1];
    step_en = {two & (rar ^ ral),
               (rar ^ ral) | (two & ~rar & ~ral),
               v[0],
               v[5] | v[4],
               v[7] | v[6]};
  endfunction

  // First enabled step at or after position 'from', else DONE.
  function automatic logic [6:0] next_step(input logic [4:0] en, input int from);
    logic [6:0] r;
    r = ST_DONE;
    for (int i = 4; i >= 0; i--) begin
      if (i >= from && en[i]) r = 7'(1) << (i + 1);
    end
    return r;
  endfunction

  assign en_q    = step_en(ir_q);
  assign state_o = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          ir_d = bus.ir[7:0];
          if (bus.ir[11:8] != 4'b1110) state_d = ST_DONE;
          else                         state_d = next_step(step_en(bus.ir[7:0]), 0);
        end
      end
      ST_CLR:  state_d = next_step(en_q, 1);
      ST_CMP:  state_d = next_step(en_q, 2);
      ST_INC:  state_d = next_step(en_q, 3);
      ST_ROT1: state_d = next_step(en_q, 4);
      ST_ROT2: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q != ST_IDLE);
    bus.done      = (state_q == ST_DONE);
    bus.ac_ck     = 1'b0;
    bus.ac_clr    = 1'b0;
    bus.ac_cmp    = 1'b0;
    bus.ac_inc    = 1'b0;
    bus.rot_left  = 1'b0;
    bus.rot_right = 1'b0;
    bus.rot_bsw   = 1'b0;
    bus.link_ck   = 1'b0;
    bus.link_cll  = 1'b0;
    bus.link_cml  = 1'b0;
    bus.link_set  = 1'b0;
    case (state_q)
      ST_CLR: begin
        bus.ac_ck    = ir_q[7];
        bus.ac_clr   = ir_q[7];
        bus.link_ck  = ir_q[6];
        bus.link_cll = ir_q[6];
      end
      ST_CMP: begin
        bus.ac_ck    = ir_q[5];
        bus.ac_cmp   = ir_q[5];
        bus.link_ck  = ir_q[4];
        bus.link_cml = ir_q[4];
      end
      ST_INC: begin
        bus.ac_ck    = 1'b1;
        bus.ac_inc   = 1'b1;
        bus.link_ck  = 1'b1;
        bus.link_cml = bus.iac_carry;
      end
      ST_ROT1, ST_ROT2: begin
        // ROT2 is only entered for RTR/RTL, so it shares the ROT1 decode.
        bus.ac_ck = 1'b1;
        if (ir_q[3] ^ ir_q[2]) begin
          bus.rot_right = ir_q[3];
          bus.rot_left  = ir_q[2];
          bus.link_set  = 1'b1;
          bus.link_ck   = 1'b1;
        end else begin
          bus.rot_bsw = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_opr1_sequencer.sv
// Bench for opr1_sequencer: a stand-in AC/Link datapath follows the strobes, and
// a PDP-8 architectural model predicts per-cycle strobes and final AC/L.
module tb_opr1_sequencer;

  logic        clk;
  logic        reset;
  logic [6:0]  state_o;
  logic [11:0] dp_ac;
  logic        dp_l;
  logic        pre_ld;
  logic [11:0] pre_ac;
  logic        pre_l;
  int          n_checks;
  int          n_fail;

  logic [12:0] exp_q[$];
  logic [11:0] exp_ac;
  logic        exp_l;

  localparam logic [12:0] V_BUSY = 13'h1000, V_DONE = 13'h0800, V_ACCK = 13'h0400,
                          V_CLR  = 13'h0200, V_CMP  = 13'h0100, V_INC  = 13'h0080,
                          V_RL   = 13'h0040, V_RR   = 13'h0020, V_BSW  = 13'h0010,
                          V_LCK  = 13'h0008, V_LCLL = 13'h0004, V_LCML = 13'h0002,
                          V_LSET = 13'h0001;

  opr1_sequencer_if bus ();

  opr1_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.iac_carry = (dp_ac == 12'o7777);

  // Stand-in datapath: loads on the edge ending each strobe cycle.
  always @(posedge clk) begin
    if (pre_ld) begin
      dp_ac <= pre_ac;
      dp_l  <= pre_l;
    end else begin
      if (bus.ac_ck) begin
        if (bus.ac_clr)         dp_ac <= '0;
        else if (bus.ac_cmp)    dp_ac <= ~dp_ac;
        else if (bus.ac_inc)    dp_ac <= dp_ac + 12'd1;
        else if (bus.rot_right) dp_ac <= {dp_l, dp_ac[11:1]};
        else if (bus.rot_left)  dp_ac <= {dp_ac[10:0], dp_l};
        else if (bus.rot_bsw)   dp_ac <= {dp_ac[5:0], dp_ac[11:6]};
      end
      if (bus.link_ck) begin
        if (bus.link_cll)      dp_l <= 1'b0;
        else if (bus.link_cml) dp_l <= ~dp_l;
        else if (bus.link_set) dp_l <= bus.rot_right ? dp_ac[0] : dp_ac[11];
      end
    end
  end

  function automatic logic [12:0] obs_vec();
    return {bus.busy, bus.done, bus.ac_ck, bus.ac_clr, bus.ac_cmp, bus.ac_inc,
            bus.rot_left, bus.rot_right, bus.rot_bsw,
            bus.link_ck, bus.link_cll, bus.link_cml, bus.link_set};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural model: one entry per busy cycle, then the idle cycle after.
  task automatic build_expect(input logic [11:0] v, input logic [11:0] a0, input logic l0);
    logic [11:0] a;
    logic        lk, carry, rar, ral, two;
    logic [12:0] t;
    a = a0;
    lk = l0;
    rar = v[3];
    ral = v[2];
    two = v[1];
    exp_q.delete();
    if (v[11:8] == 4'b1110) begin
      if (v[7] || v[6]) begin
        exp_q.push_back(V_BUSY | (v[7] ? (V_ACCK | V_CLR) : 13'h0) | (v[6] ? (V_LCK | V_LCLL) : 13'h0));
        if (v[7]) a = '0;
        if (v[6]) lk = 1'b0;
      end
      if (v[5] || v[4]) begin
        exp_q.push_back(V_BUSY | (v[5] ? (V_ACCK | V_CMP) : 13'h0) | (v[4] ? (V_LCK | V_LCML) : 13'h0));
        if (v[5]) a = ~a;
        if (v[4]) lk = ~lk;
      end
      if (v[0]) begin
        carry = (a == 12'o7777);
        exp_q.push_back(V_BUSY | V_ACCK | V_INC | V_LCK | (carry ? V_LCML : 13'h0));
        a = a + 12'd1;
        if (carry) lk = ~lk;
      end
      if (rar != ral) begin
        for (int k = 0; k < (two ? 2 : 1); k++) begin
          exp_q.push_back(V_BUSY | V_ACCK | V_LCK | V_LSET | (rar ? V_RR : V_RL));
          t = {lk, a};
          t = rar ? {t[0], t[12:1]} : {t[11:0], t[12]};
          {lk, a} = t;
        end
      end else if (two && !rar && !ral) begin
        exp_q.push_back(V_BUSY | V_ACCK | V_BSW);
        a = {a[5:0], a[11:6]};
      end
    end
    exp_q.push_back(V_BUSY | V_DONE);
    exp_q.push_back(13'h0);
    exp_ac = a;
    exp_l  = lk;
  endtask

  task automatic preload(input logic [11:0] a, input logic l);
    pre_ac = a;
    pre_l  = l;
    pre_ld = 1'b1;
    @(negedge clk);
    pre_ld = 1'b0;
  endtask

  task automatic run_instr(input string tag, input logic [11:0] v, input logic [11:0] a0,
                           input logic l0, input bit extra_start);
    logic [12:0] e;
    int          cyc;
    preload(a0, l0);
    build_expect(v, a0, l0);
    bus.ir = v;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq($sformatf("%s cyc%0d", tag, cyc), 32'(obs_vec()), 32'(e));
      check_eq($sformatf("%s onehot%0d", tag, cyc), 32'($onehot(state_o)), 32'd1);
      bus.start = (extra_start && cyc == 0);
      cyc++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check_eq({tag, " ac"}, 32'(dp_ac), 32'(exp_ac));
    check_eq({tag, " link"}, 32'(dp_l), 32'(exp_l));
  endtask

  initial begin
    logic [11:0] rv;
    n_checks = 0;
    n_fail   = 0;
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.ir    = 12'o7300;
    pre_ac    = 12'o1234;
    pre_l     = 1'b1;
    pre_ld    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("reset outputs", 32'(obs_vec()), 32'd0);
    end
    check_eq("reset state", 32'(state_o), 32'd1);
    pre_ld = 1'b0;
    reset  = 1'b0;
    build_expect(12'o7300, 12'o1234, 1'b1);
    check_eq("rel idle", 32'(obs_vec()), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; exp_q.size() > 0; c++) begin
      check_eq($sformatf("cla_cll cyc%0d", c), 32'(obs_vec()), 32'(exp_q.pop_front()));
      @(negedge clk);
    end
    check_eq("cla_cll ac", 32'(dp_ac), 32'(exp_ac));
    check_eq("cla_cll link", 32'(dp_l), 32'(exp_l));

    run_instr("cia", 12'o7041, 12'o0000, 1'b0, 1'b0);
    run_instr("rtl", 12'o7006, 12'o4001, 1'b0, 1'b0);
    run_instr("bsw", 12'o7002, 12'o1234, 1'b1, 1'b0);
    run_instr("nop", 12'o7000, 12'o5555, 1'b1, 1'b0);
    run_instr("nongrp", 12'o1234, 12'o0707, 1'b0, 1'b0);
    run_instr("rar_ral", 12'o7014, 12'o2222, 1'b1, 1'b0);
    run_instr("cll_cml", 12'o7120, 12'o0000, 1'b1, 1'b0);
    run_instr("rtr_restart", 12'o7012, 12'o0001, 1'b1, 1'b1);
    run_instr("all_restart", 12'o7377, 12'o0000, 1'b0, 1'b1);

    // Reset in the INC cycle of CIA aborts without done.
    preload(12'o0000, 1'b0);
    bus.ir = 12'o7041;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("abort cmp", 32'(obs_vec()), 32'(V_BUSY | V_ACCK | V_CMP));
    @(negedge clk);
    check_eq("abort inc", 32'(obs_vec()), 32'(V_BUSY | V_ACCK | V_INC | V_LCK | V_LCML));
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort rst", 32'(obs_vec()), 32'd0);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq("abort after", 32'(obs_vec()), 32'd0);
      check_eq("abort idle", 32'(state_o), 32'd1);
    end

    for (int n = 0; n < 60; n++) begin
      rv = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 3) != 0) rv[11:8] = 4'b1110;
      run_instr($sformatf("rnd%0d_%o", n, rv), rv, 12'($urandom_range(0, 4095)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
